// File: rtl/stopwatch_pkg.sv
// Shared state encoding for the stopwatch control path and its bench.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAP  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_LAP  = ST_LAP,
    S_STOP = ST_STOP
  } sw_state_e;

  // RUN and LAP both keep time; LAP only freezes the display.
  function automatic logic is_counting(input sw_state_e s);
    return (s == S_RUN) || (s == S_LAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF synchroniser -> stability debounce -> one-cycle press pulse.
module btn_debounce #(
  parameter int DB_CYCLES  = 500_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int              CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             pressed_raw;
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Everything past this point works in "pressed = 1" sense.
  assign pressed_raw = btn_raw ^ ACTIVE_LOW;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= pressed_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons drive the FSM, which gates the hundredths
// prescaler and produces ena/clear/oen for the downstream BCD counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV       = 500_000,
  parameter int DB_CYCLES      = 500_000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       ena,
  output logic       clear,
  output logic       oen,
  output logic [1:0] state
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          start_p, lap_p;
  sw_state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ena_q, ena_d;
  logic          clear_q, clear_d;
  logic          oen_q, oen_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_start (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_start_stop),
    .press  (start_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_lap (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_lap_reset),
    .press  (lap_p)
  );

  // Start always wins; a lap press in the same cycle is simply ignored.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_p)    state_d = S_RUN;
        else if (lap_p) clear_d = 1'b1;
      end
      S_RUN: begin
        if (start_p)    state_d = S_STOP;
        else if (lap_p) state_d = S_LAP;
      end
      S_LAP: begin
        if (start_p)    state_d = S_STOP;
        else if (lap_p) state_d = S_RUN;
      end
      S_STOP: begin
        if (start_p) begin
          state_d = S_RUN;
        end else if (lap_p) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // STOP keeps the partial hundredth so a resume does not lose time.
    if (is_counting(state_q)) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end else if (state_d == S_IDLE) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q;
    end

    ena_d = is_counting(state_d) && (presc_d == PRESC_LAST);
    oen_d = (state_d == S_LAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      ena_q   <= 1'b0;
      clear_q <= 1'b0;
      oen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ena_q   <= ena_d;
      clear_q <= clear_d;
      oen_q   <= oen_d;
    end
  end

  assign ena   = ena_q;
  assign clear = clear_q;
  assign oen   = oen_q;
  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4, DB_CYCLES=3, active-low buttons.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int TD = 4;
  // Cycle in which the first start press puts the FSM into RUN (last glitch edge at 38, +7).
  localparam int E  = 45;

  typedef struct {
    int         cyc;
    logic       ena;
    logic       clear;
    logic       oen;
    logic [1:0] st;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b1;
  logic       btn_lr = 1'b1;
  logic       ena, clear, oen;
  logic [1:0] state;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         win_enas = 0;
  logic [1:0] prev_st = ST_IDLE;
  logic       prev_oen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(3), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_start_stop(btn_ss),
    .btn_lap_reset (btn_lr),
    .ena           (ena),
    .clear         (clear),
    .oen           (oen),
    .state         (state)
  );

  task automatic push_ev(input int c, input logic e, input logic cl, input logic o,
                         input logic [1:0] s);
    ev_t ev;
    ev.cyc = c; ev.ena = e; ev.clear = cl; ev.oen = o; ev.st = s;
    exp_q.push_back(ev);
  endtask

  // ena expected where the cycle is TD-1 past the last cycle the prescaler sat at 0
  task automatic push_enas(input int from, input int to, input int base, input logic o,
                           input logic [1:0] s);
    for (int c = from; c <= to; c++) begin
      if ((c - base) % TD == TD - 1) push_ev(c, 1'b1, 1'b0, o, s);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle with ena/clear high or a state/oen change is an event to match.
  initial begin
    ev_t ev;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_st  = state;
        prev_oen = oen;
      end else begin
        if (cyc >= E + 1 && cyc <= E + 100 && ena) win_enas++;
        if (ena || clear || state != prev_st || oen != prev_oen) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: cyc=%0d ena=%b clear=%b oen=%b state=%0d, expected none",
                     cyc, ena, clear, oen, state);
          end else begin
            ev = exp_q.pop_front();
            if (ev.cyc != cyc || ev.ena !== ena || ev.clear !== clear ||
                ev.oen !== oen || ev.st !== state) begin
              bad++;
              $display("FAIL event: got cyc=%0d ena=%b clear=%b oen=%b state=%0d, expected cyc=%0d ena=%b clear=%b oen=%b state=%0d",
                       cyc, ena, clear, oen, state, ev.cyc, ev.ena, ev.clear, ev.oen, ev.st);
            end
          end
        end
        prev_st  = state;
        prev_oen = oen;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(3);
    check("reset_ena", ena, 0);
    check("reset_clear", clear, 0);
    check("reset_oen", oen, 0);
    check("reset_state", state, ST_IDLE);
    wait_cyc(5);
    rst = 1'b0;

    // Lap in IDLE: clear pulse only.
    wait_cyc(10);
    push_ev(17, 1'b0, 1'b1, 1'b0, ST_IDLE);
    btn_lr = 1'b0;
    wait_cyc(15);
    btn_lr = 1'b1;

    // Bouncing start press, then held for 50 clocks.
    wait_cyc(30);
    push_ev(E, 1'b0, 1'b0, 1'b0, ST_RUN);
    push_enas(E + 1, E + 107, E, 1'b0, ST_RUN);
    btn_ss = 1'b0;
    wait_cyc(32); btn_ss = 1'b1;
    wait_cyc(34); btn_ss = 1'b0;
    wait_cyc(36); btn_ss = 1'b1;
    wait_cyc(38); btn_ss = 1'b0;
    wait_cyc(E + 43); btn_ss = 1'b1;

    // Lap freeze and return to RUN.
    wait_cyc(E + 101);
    check("run_ena_count", win_enas, 25);
    push_ev(E + 108, 1'b0, 1'b0, 1'b1, ST_LAP);
    push_enas(E + 109, E + 127, E, 1'b1, ST_LAP);
    btn_lr = 1'b0;
    wait_cyc(E + 110);
    check("lap_oen", oen, 1);
    check("lap_state", state, ST_LAP);
    wait_cyc(E + 111); btn_lr = 1'b1;
    wait_cyc(E + 121);
    push_ev(E + 128, 1'b0, 1'b0, 1'b0, ST_RUN);
    push_enas(E + 129, E + 140, E, 1'b0, ST_RUN);
    btn_lr = 1'b0;
    wait_cyc(E + 130);
    check("unlap_oen", oen, 0);
    check("unlap_state", state, ST_RUN);
    wait_cyc(E + 131); btn_lr = 1'b1;

    // Stop with prescaler at 1, resume keeps the phase.
    wait_cyc(E + 134);
    push_ev(E + 141, 1'b0, 1'b0, 1'b0, ST_STOP);
    btn_ss = 1'b0;
    wait_cyc(E + 139); btn_ss = 1'b1;
    wait_cyc(E + 145);
    check("stop_state", state, ST_STOP);
    wait_cyc(E + 150);
    push_ev(E + 157, 1'b0, 1'b0, 1'b0, ST_RUN);
    push_enas(E + 158, E + 176, E, 1'b0, ST_RUN);
    btn_ss = 1'b0;
    wait_cyc(E + 155); btn_ss = 1'b1;

    // Stop then lap: single clear, back to IDLE.
    wait_cyc(E + 170);
    push_ev(E + 177, 1'b0, 1'b0, 1'b0, ST_STOP);
    btn_ss = 1'b0;
    wait_cyc(E + 175); btn_ss = 1'b1;
    wait_cyc(E + 185);
    push_ev(E + 192, 1'b0, 1'b1, 1'b0, ST_IDLE);
    btn_lr = 1'b0;
    wait_cyc(E + 190); btn_lr = 1'b1;
    wait_cyc(E + 195);
    check("idle_state", state, ST_IDLE);

    // Fresh start: prescaler restarted from 0.
    wait_cyc(E + 200);
    push_ev(E + 207, 1'b0, 1'b0, 1'b0, ST_RUN);
    push_enas(E + 208, E + 226, E + 207, 1'b0, ST_RUN);
    btn_ss = 1'b0;
    wait_cyc(E + 205); btn_ss = 1'b1;

    // Both buttons together, press pulses land on a terminal-count cycle.
    wait_cyc(E + 220);
    push_ev(E + 227, 1'b0, 1'b0, 1'b0, ST_STOP);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    wait_cyc(E + 225);
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    wait_cyc(E + 235);
    check("both_state", state, ST_STOP);
    check("both_oen", oen, 0);

    // Resume, then async reset with the prescaler at 2.
    wait_cyc(E + 240);
    push_ev(E + 247, 1'b0, 1'b0, 1'b0, ST_RUN);
    push_enas(E + 248, E + 256, E + 247, 1'b0, ST_RUN);
    btn_ss = 1'b0;
    wait_cyc(E + 245); btn_ss = 1'b1;
    wait_cyc(E + 257);
    rst = 1'b1;
    #1;
    check("midrst_ena", ena, 0);
    check("midrst_clear", clear, 0);
    check("midrst_oen", oen, 0);
    check("midrst_state", state, ST_IDLE);
    wait_cyc(E + 260);
    rst = 1'b0;
    wait_cyc(E + 275);
    check("post_rst_state", state, ST_IDLE);

    wait_cyc(E + 280);
    push_ev(E + 287, 1'b0, 1'b0, 1'b0, ST_RUN);
    push_enas(E + 288, E + 300, E + 287, 1'b0, ST_RUN);
    btn_ss = 1'b0;
    wait_cyc(E + 285); btn_ss = 1'b1;

    wait_cyc(E + 300);
    check("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
